// File: rtl/conv1_window_gen.sv
// conv1_window_gen: turns a raster-order pixel stream into registered 3x3 windows
// for the conv1 filter stage. Only fully interior (no-padding) positions are emitted.
// Optional feature: define CONV1_WIN_COORD_EN to add out_row/out_col outputs
// carrying the output-map coordinate of each emitted window.
module conv1_window_gen #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IMG_W  = 28,
  parameter int unsigned IMG_H  = 28
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     valid_in,
  input  logic [DATA_W-1:0]        pixel_in,
  output logic [DATA_W-1:0]        window [0:8],
  output logic                     valid_out,
`ifdef CONV1_WIN_COORD_EN
  output logic [$clog2(IMG_H)-1:0] out_row,
  output logic [$clog2(IMG_W)-1:0] out_col,
`endif
  output logic                     frame_done
);

  localparam int unsigned ColW    = $clog2(IMG_W);
  localparam int unsigned RowW    = $clog2(IMG_H);
  // Registered taps; together with the live pixel_in word they form the
  // 2*IMG_W+3 word line/pixel delay the window is cut from.
  localparam int unsigned NumTaps = 2 * IMG_W + 2;

  localparam logic [ColW-1:0] ColLast = ColW'(IMG_W - 1);
  localparam logic [RowW-1:0] RowLast = RowW'(IMG_H - 1);
  localparam logic [ColW-1:0] ColTwo  = ColW'(2);
  localparam logic [RowW-1:0] RowTwo  = RowW'(2);

  logic [DATA_W-1:0] r_taps   [NumTaps];
  logic [DATA_W-1:0] w_line   [NumTaps+1];
  logic [DATA_W-1:0] w_window [0:8];
  logic [ColW-1:0]   r_col, w_col_d;
  logic [RowW-1:0]   r_row, w_row_d;
  logic              w_win_valid;
  logic              w_last;

  // Delay line view: index 0 is the incoming pixel, index n is the pixel n beats older.
  always_comb begin
    w_line[0] = pixel_in;
    for (int i = 0; i < NumTaps; i++) begin
      w_line[i+1] = r_taps[i];
    end
  end

  // Cut the 3x3 window out of the delay line; window[8] is the newest pixel.
  always_comb begin
    for (int a = 0; a < 3; a++) begin
      for (int b = 0; b < 3; b++) begin
        w_window[3*a+b] = w_line[(2-a)*IMG_W + (2-b)];
      end
    end
  end

  // Raster position of the next accepted pixel; frames wrap with no flush.
  always_comb begin
    w_col_d = r_col;
    w_row_d = r_row;
    if (valid_in) begin
      if (r_col == ColLast) begin
        w_col_d = '0;
        w_row_d = (r_row == RowLast) ? '0 : r_row + 1'b1;
      end else begin
        w_col_d = r_col + 1'b1;
      end
    end
  end

  // A window is complete when the accepted pixel is at least two rows and two columns in.
  always_comb begin
    w_win_valid = valid_in && (r_row >= RowTwo) && (r_col >= ColTwo);
    w_last      = (r_row == RowLast) && (r_col == ColLast);
  end

  // Shift the delay line only on accepted beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NumTaps; i++) begin
        r_taps[i] <= '0;
      end
    end else if (valid_in) begin
      for (int i = 0; i < NumTaps; i++) begin
        r_taps[i] <= w_line[i];
      end
    end
  end

  // Position counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else begin
      r_col <= w_col_d;
      r_row <= w_row_d;
    end
  end

  // Registered window outputs; the window holds between valid pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
      for (int k = 0; k < 9; k++) begin
        window[k] <= '0;
      end
    end else begin
      valid_out  <= w_win_valid;
      frame_done <= w_win_valid && w_last;
      if (w_win_valid) begin
        for (int k = 0; k < 9; k++) begin
          window[k] <= w_window[k];
        end
      end
    end
  end

`ifdef CONV1_WIN_COORD_EN
  // Output-map coordinate of the window centre, updated with the window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_row <= '0;
      out_col <= '0;
    end else if (w_win_valid) begin
      out_row <= r_row - RowTwo;
      out_col <= r_col - ColTwo;
    end
  end
`endif

endmodule

// File: tb/tb_conv1_window_gen.sv
// Directed bench for conv1_window_gen: a 5x4 instance and a default 28x28 instance.
module tb_conv1_window_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        v5, v28;
  logic [31:0] p5, p28;
  logic [31:0] win5  [0:8];
  logic [31:0] win28 [0:8];
  logic        vo5, fd5, vo28, fd28;
`ifdef CONV1_WIN_COORD_EN
  logic [1:0]  orow5;
  logic [2:0]  ocol5;
  logic [4:0]  orow28, ocol28;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int pulses5, fdone5, pulses28, fdone28;

  int exp_first [9] = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
  int exp_last  [9] = '{7, 8, 9, 12, 13, 14, 17, 18, 19};
  int exp_f2    [9] = '{100, 101, 102, 105, 106, 107, 110, 111, 112};
  int exp_rst   [9] = '{200, 201, 202, 205, 206, 207, 210, 211, 212};
  int exp_big   [9] = '{0, 1, 2, 28, 29, 30, 56, 57, 58};

  conv1_window_gen #(.DATA_W(32), .IMG_W(5), .IMG_H(4)) u_dut5 (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_in   (v5),
    .pixel_in   (p5),
    .window     (win5),
    .valid_out  (vo5),
`ifdef CONV1_WIN_COORD_EN
    .out_row    (orow5),
    .out_col    (ocol5),
`endif
    .frame_done (fd5)
  );

  conv1_window_gen u_dut28 (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_in   (v28),
    .pixel_in   (p28),
    .window     (win28),
    .valid_out  (vo28),
`ifdef CONV1_WIN_COORD_EN
    .out_row    (orow28),
    .out_col    (ocol28),
`endif
    .frame_done (fd28)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One accepted pixel on the 5x4 instance, then check the registered result.
  task automatic feed5(input int base, input int idx);
    int r, c;
    r = idx / 5;
    c = idx % 5;
    @(negedge clk);
    v5 = 1'b1;
    p5 = 32'(base + idx);
    @(posedge clk);
    #1;
    v5 = 1'b0;
    check_eq("vo5", 64'(vo5), 64'(r >= 2 && c >= 2));
    check_eq("fd5", 64'(fd5), 64'(r == 3 && c == 4));
    if (vo5) pulses5++;
    if (fd5) fdone5++;
    if (r >= 2 && c >= 2) begin
      for (int k = 0; k < 9; k++) begin
        check_eq("win5", 64'(win5[k]), 64'(base + (r - 2 + k / 3) * 5 + (c - 2 + k % 3)));
      end
`ifdef CONV1_WIN_COORD_EN
      check_eq("orow5", 64'(orow5), 64'(r - 2));
      check_eq("ocol5", 64'(ocol5), 64'(c - 2));
`endif
    end
  endtask

  task automatic idle5();
    @(negedge clk);
    v5 = 1'b0;
    @(posedge clk);
    #1;
    check_eq("gap_vo5", 64'(vo5), 64'd0);
    check_eq("gap_fd5", 64'(fd5), 64'd0);
  endtask

  task automatic feed28(input int idx);
    int r, c;
    r = idx / 28;
    c = idx % 28;
    @(negedge clk);
    v28 = 1'b1;
    p28 = 32'(idx);
    @(posedge clk);
    #1;
    v28 = 1'b0;
    check_eq("vo28", 64'(vo28), 64'(r >= 2 && c >= 2));
    check_eq("fd28", 64'(fd28), 64'(r == 27 && c == 27));
    if (vo28) pulses28++;
    if (fd28) fdone28++;
    if (r >= 2 && c >= 2) begin
      for (int k = 0; k < 9; k++) begin
        check_eq("win28", 64'(win28[k]), 64'(idx - (2 - k / 3) * 28 - (2 - k % 3)));
      end
    end
  endtask

  task automatic check_win5(input string tag, input int exp [9]);
    for (int k = 0; k < 9; k++) begin
      check_eq(tag, 64'(win5[k]), 64'(exp[k]));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    v5    = 1'b0;
    v28   = 1'b0;
    p5    = '0;
    p28   = '0;
    #1;
    check_eq("rst_vo5", 64'(vo5), 64'd0);
    check_eq("rst_fd5", 64'(fd5), 64'd0);
    check_eq("rst_vo28", 64'(vo28), 64'd0);
    for (int k = 0; k < 9; k++) check_eq("rst_win5", 64'(win5[k]), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Continuous 5x4 frame.
    pulses5 = 0;
    fdone5  = 0;
    for (int i = 0; i < 20; i++) begin
      feed5(0, i);
      if (i == 12) check_win5("t1_first", exp_first);
      if (i == 19) begin
        check_win5("t1_last", exp_last);
        check_eq("t1_fd_last", 64'(fd5), 64'd1);
      end
    end
    check_eq("t1_pulses", 64'(pulses5), 64'd6);
    check_eq("t1_fdone", 64'(fdone5), 64'd1);

    // Same frame with three idle cycles after every second pixel.
    pulses5 = 0;
    fdone5  = 0;
    for (int i = 0; i < 20; i++) begin
      feed5(0, i);
      if (i % 2 == 1) repeat (3) idle5();
    end
    check_eq("t2_pulses", 64'(pulses5), 64'd6);
    check_eq("t2_fdone", 64'(fdone5), 64'd1);

    // Two frames back to back.
    pulses5 = 0;
    fdone5  = 0;
    for (int i = 0; i < 20; i++) feed5(0, i);
    for (int i = 0; i < 20; i++) begin
      feed5(100, i);
      if (i == 12) check_win5("t3_first", exp_f2);
    end
    check_eq("t3_pulses", 64'(pulses5), 64'd12);
    check_eq("t3_fdone", 64'(fdone5), 64'd2);

    // Reset mid-frame after pixel 7.
    for (int i = 0; i < 8; i++) feed5(0, i);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("t4_vo5", 64'(vo5), 64'd0);
    for (int k = 0; k < 9; k++) check_eq("t4_win0", 64'(win5[k]), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    pulses5 = 0;
    for (int i = 0; i < 20; i++) begin
      feed5(200, i);
      if (i == 12) check_win5("t4_first", exp_rst);
    end
    check_eq("t4_pulses", 64'(pulses5), 64'd6);

    // Default 28x28 frame.
    pulses28 = 0;
    fdone28  = 0;
    for (int i = 0; i < 784; i++) begin
      feed28(i);
      if (i == 29) check_eq("t5_no_r1c1", 64'(vo28), 64'd0);
      if (i == 58) begin
        for (int k = 0; k < 9; k++) check_eq("t5_first", 64'(win28[k]), 64'(exp_big[k]));
      end
    end
    check_eq("t5_pulses", 64'(pulses28), 64'd676);
    check_eq("t5_fdone", 64'(fdone28), 64'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
